// File: rtl/div_pkg.sv
// Shared types for the iterative RV32M divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic op_is_signed(div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract divisor.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    // A bit shifted out of the top means the value already exceeds the divisor.
    always_comb begin
        sh    = {rem_i[XLEN-1:0], bit_i};
        diff  = sh - {1'b0, div_i};
        q_o   = rem_i[XLEN] | (sh >= {1'b0, div_i});
        rem_o = q_o ? diff : sh;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU/REM/REMU unit in Execute; stalls the pipe while busy.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            DivStartE,
    input  logic [1:0]      DivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            DivKillE,
    output logic            StallReqE,
    output logic            DivValidE,
    output logic [XLEN-1:0] DivResultE
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic [XLEN-1:0]  res_q, res_d;
    div_op_t          op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    div_op_t         op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, ovf, special, accept, last;
    logic [XLEN-1:0] spec_res;
    logic [XLEN:0]   step_rem;
    logic            step_q;
    logic [XLEN-1:0] quo_nxt, q_fix, r_fix;

    always_comb begin
        op_in    = div_op_t'(DivOpE);
        a_neg    = op_is_signed(op_in) & SrcAE[XLEN-1];
        b_neg    = op_is_signed(op_in) & SrcBE[XLEN-1];
        a_abs    = a_neg ? -SrcAE : SrcAE;
        b_abs    = b_neg ? -SrcBE : SrcBE;
        div_zero = (SrcBE == '0);
        ovf      = op_is_signed(op_in) && (SrcAE == MOST_NEG)
                   && (SrcBE == '1);
        special  = div_zero || ovf;
        if (div_zero) begin
            spec_res = op_is_rem(op_in) ? SrcAE : '1;
        end else begin
            spec_res = op_is_rem(op_in) ? '0 : SrcAE;
        end
        accept = (state_q == IDLE) && DivStartE && !DivKillE;
        last   = (state_q == CALC) && (cnt_q == LAST);
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[XLEN-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        quo_nxt = {quo_q[XLEN-2:0], step_q};
        q_fix   = qneg_q ? -quo_nxt : quo_nxt;
        r_fix   = rneg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (DivStartE && !DivKillE) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (DivKillE) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallReqE = 1'b0;
        DivValidE = 1'b0;
        if (!rst && !DivKillE) begin
            unique case (state_q)
                IDLE:    StallReqE = DivStartE;
                CALC:    StallReqE = 1'b1;
                DONE:    DivValidE = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        op_d   = op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        res_d  = res_q;
        if (accept) begin
            div_d  = b_abs;
            quo_d  = a_abs;
            rem_d  = '0;
            cnt_d  = '0;
            op_d   = op_in;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            if (special) begin
                res_d = spec_res;
            end
        end else if (state_q == CALC && !DivKillE) begin
            rem_d = step_rem;
            quo_d = quo_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                res_d = op_is_rem(op_q) ? r_fix : q_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            op_q   <= DIV;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            op_q   <= op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            res_q  <= res_d;
        end
    end

    assign DivResultE = res_q;

endmodule
